// File: rtl/fmul_share_ctrl.sv
// Arbiter and pipeline-occupancy controller sharing one fmul unit
// among NREQ requesters, with per-stage stall enables and a flush.
module fmul_share_ctrl #(
    parameter int EXPWIDTH  = 5,
    parameter int PRECISION = 11,
    parameter int LAT       = 3,
    parameter int NREQ      = 2,
    localparam int W        = EXPWIDTH + PRECISION
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic [NREQ*W-1:0]   req_a_i,
    input  logic [NREQ*W-1:0]   req_b_i,
    input  logic [NREQ*3-1:0]   req_rm_i,
    input  logic                flush_i,
    output logic                mul_valid_o,
    output logic [W-1:0]        mul_a_o,
    output logic [W-1:0]        mul_b_o,
    output logic [2:0]          mul_rm_o,
    output logic [LAT-1:0]      stage_en_o,
    input  logic [W-1:0]        mul_result_i,
    input  logic [4:0]          mul_fflags_i,
    output logic [NREQ-1:0]     rsp_valid_o,
    input  logic [NREQ-1:0]     rsp_ready_i,
    output logic [W-1:0]        rsp_data_o,
    output logic [4:0]          rsp_fflags_o,
    output logic                busy_o,
    output logic [15:0]         stall_cnt_o
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LAT-1:0] vld;
    logic [LAT-1:0] adv;
    logic [IDW-1:0] id [LAT];
    logic [IDW-1:0] rr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] cand;
    logic           gnt_vld;
    logic           issue;
    logic [15:0]    stall_cnt;

    // A stage may load when empty or when its successor moves on.
    always_comb begin
        adv = '0;
        adv[LAT-1] = !vld[LAT-1] | rsp_ready_i[id[LAT-1]];
        for (int k = LAT-2; k >= 0; k--) begin
            adv[k] = !vld[k] | adv[k+1];
        end
    end

    // Scan downward so the candidate closest to rr is the last to win.
    always_comb begin
        grant   = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int j = NREQ-1; j >= 0; j--) begin
            cand = IDW'((int'(rr) + j) % NREQ);
            if (req_valid_i[cand]) begin
                grant   = cand;
                gnt_vld = 1'b1;
            end
        end
    end

    assign issue = gnt_vld & adv[0] & !flush_i & rst_n;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = issue & (grant == IDW'(i));
        end
    end

    always_comb begin
        mul_valid_o = issue;
        mul_a_o     = '0;
        mul_b_o     = '0;
        mul_rm_o    = '0;
        if (issue) begin
            mul_a_o  = req_a_i[int'(grant)*W +: W];
            mul_b_o  = req_b_i[int'(grant)*W +: W];
            mul_rm_o = req_rm_i[int'(grant)*3 +: 3];
        end
    end

    assign stage_en_o = adv & {LAT{!flush_i}};

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_o[i] = vld[LAT-1] & (id[LAT-1] == IDW'(i));
        end
    end

    assign rsp_data_o   = vld[LAT-1] ? mul_result_i : '0;
    assign rsp_fflags_o = vld[LAT-1] ? mul_fflags_i : '0;
    assign busy_o       = |vld;
    assign stall_cnt_o  = stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            rr        <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < LAT; k++) begin
                id[k] <= '0;
            end
        end else begin
            if (vld[LAT-1] && !adv[LAT-1] && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_i) begin
                vld <= '0;
            end else begin
                if (adv[0]) begin
                    vld[0] <= issue;
                    id[0]  <= grant;
                end
                for (int k = 1; k < LAT; k++) begin
                    if (adv[k]) begin
                        vld[k] <= vld[k-1];
                        id[k]  <= id[k-1];
                    end
                end
                if (issue) begin
                    rr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Randomized and directed bench for fmul_share_ctrl against a
// slot-list reference model and an emulated fmul data pipeline.
module tb_fmul_share_ctrl;

    localparam int EW = 5;
    localparam int PR = 11;
    localparam int L  = 3;
    localparam int N  = 2;
    localparam int W  = EW + PR;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid_i;
    logic [N-1:0]     req_ready_o;
    logic [N*W-1:0]   req_a_i;
    logic [N*W-1:0]   req_b_i;
    logic [N*3-1:0]   req_rm_i;
    logic             flush_i;
    logic             mul_valid_o;
    logic [W-1:0]     mul_a_o;
    logic [W-1:0]     mul_b_o;
    logic [2:0]       mul_rm_o;
    logic [L-1:0]     stage_en_o;
    logic [W-1:0]     mul_result_i;
    logic [4:0]       mul_fflags_i;
    logic [N-1:0]     rsp_valid_o;
    logic [N-1:0]     rsp_ready_i;
    logic [W-1:0]     rsp_data_o;
    logic [4:0]       rsp_fflags_o;
    logic             busy_o;
    logic [15:0]      stall_cnt_o;

    always #5 clk = ~clk;

    fmul_share_ctrl #(
        .EXPWIDTH (EW),
        .PRECISION(PR),
        .LAT      (L),
        .NREQ     (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_rm_i    (req_rm_i),
        .flush_i     (flush_i),
        .mul_valid_o (mul_valid_o),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_rm_o    (mul_rm_o),
        .stage_en_o  (stage_en_o),
        .mul_result_i(mul_result_i),
        .mul_fflags_i(mul_fflags_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_fflags_o(rsp_fflags_o),
        .busy_o      (busy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    // Emulated fmul datapath: carries {rm, a} through the enabled stages.
    logic [W+2:0] pipe [L];
    always @(posedge clk) begin
        for (int k = 0; k < L; k++) begin
            if (stage_en_o[k]) begin
                pipe[k] <= (k == 0) ? {mul_rm_o, mul_a_o} : pipe[k-1];
            end
        end
    end
    assign mul_result_i = pipe[L-1][W-1:0];
    assign mul_fflags_i = {2'b00, pipe[L-1][W+2:W]};

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [2:0] rm;
    } op_t;

    int   checks = 0;
    int   errors = 0;
    int   slot [L];
    int   rr_m;
    int   stall_m;
    op_t  pend [$];

    logic [W-1:0] a_in [N];
    logic [W-1:0] b_in [N];
    logic [2:0]   rm_in [N];

    logic [N-1:0] obs_ready;
    logic [N-1:0] obs_rsp;
    logic [L-1:0] obs_en;
    logic         obs_mv;
    logic         obs_busy;
    logic [15:0]  obs_stall;
    logic [W-1:0] obs_data;
    logic [W-1:0] obs_res;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < L; k++) slot[k] = -1;
        rr_m    = 0;
        stall_m = 0;
        pend.delete();
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] rdy,
                        input logic fl);
        int           stuck, g, pi, idx;
        logic         occ_last, blocked, issue, run;
        logic [L-1:0] en_e;
        logic [N-1:0] rdy_e, rv_e;
        logic [W-1:0] ea, eb;
        logic [2:0]   erm;
        op_t          op;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            a_in[i]  = W'($urandom);
            b_in[i]  = W'($urandom);
            rm_in[i] = 3'($urandom);
            req_a_i[i*W +: W] = a_in[i];
            req_b_i[i*W +: W] = b_in[i];
            req_rm_i[i*3 +: 3] = rm_in[i];
        end
        req_valid_i = v;
        rsp_ready_i = rdy;
        flush_i     = fl;
        #1;
        occ_last = slot[L-1] >= 0;
        blocked  = occ_last && !rdy[slot[L-1]];
        // Stalled ops are the contiguous occupied run behind a blocked head.
        stuck = 0;
        run   = blocked;
        for (int k = L-1; k >= 0; k--) begin
            if (run && slot[k] >= 0) stuck++;
            else run = 1'b0;
        end
        for (int k = 0; k < L; k++) en_e[k] = (k < L - stuck) && !fl;
        g = -1;
        for (int j = 0; j < N; j++) begin
            idx = (rr_m + j) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        issue = (g >= 0) && (stuck < L) && !fl;
        rdy_e = issue ? (N'(1) << g) : '0;
        rv_e  = occ_last ? (N'(1) << slot[L-1]) : '0;
        ea = '0; eb = '0; erm = '0;
        if (issue) begin
            ea = a_in[g]; eb = b_in[g]; erm = rm_in[g];
        end
        check("stage_en", 32'(stage_en_o), 32'(en_e));
        check("req_ready", 32'(req_ready_o), 32'(rdy_e));
        check("mul_valid", 32'(mul_valid_o), 32'(issue));
        check("mul_a", 32'(mul_a_o), 32'(ea));
        check("mul_b", 32'(mul_b_o), 32'(eb));
        check("mul_rm", 32'(mul_rm_o), 32'(erm));
        check("rsp_valid", 32'(rsp_valid_o), 32'(rv_e));
        check("busy", 32'(busy_o), 32'(slot[0] >= 0 || slot[1] >= 0 || slot[2] >= 0));
        check("stall_cnt", 32'(stall_cnt_o), 32'(stall_m));
        if (occ_last) begin
            pi = -1;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].id == slot[L-1]) pi = i;
            end
            if (pi < 0) begin
                check("pend_exists", 32'd0, 32'd1);
            end else begin
                check("rsp_data", 32'(rsp_data_o), 32'(pend[pi].a));
                check("rsp_fflags", 32'(rsp_fflags_o), {29'd0, pend[pi].rm});
            end
        end else begin
            pi = -1;
            check("rsp_data_idle", 32'(rsp_data_o), 32'd0);
            check("rsp_fflags_idle", 32'(rsp_fflags_o), 32'd0);
        end
        obs_ready = req_ready_o;
        obs_rsp   = rsp_valid_o;
        obs_en    = stage_en_o;
        obs_mv    = mul_valid_o;
        obs_busy  = busy_o;
        obs_stall = stall_cnt_o;
        obs_data  = rsp_data_o;
        obs_res   = mul_result_i;
        @(posedge clk);
        if (blocked && stall_m < 65535) stall_m++;
        if (fl) begin
            for (int k = 0; k < L; k++) slot[k] = -1;
            pend.delete();
        end else begin
            if (occ_last && !blocked && pi >= 0) pend.delete(pi);
            for (int k = L-1; k >= 0; k--) begin
                if (k < L - stuck) begin
                    if (k == 0) slot[k] = issue ? g : -1;
                    else slot[k] = slot[k-1];
                end
            end
            if (issue) begin
                op.id = g; op.a = a_in[g]; op.rm = rm_in[g];
                pend.push_back(op);
                rr_m = (g + 1) % N;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid_i = '1;
        rsp_ready_i = '1;
        flush_i     = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_mul_valid", 32'(mul_valid_o), 32'd0);
        check("rst_mul_a", 32'(mul_a_o), 32'd0);
        check("rst_mul_b", 32'(mul_b_o), 32'd0);
        check("rst_mul_rm", 32'(mul_rm_o), 32'd0);
        check("rst_stage_en", 32'(stage_en_o), 32'h7);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        check("rst_rsp_fflags", 32'(rsp_fflags_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_stall", 32'(stall_cnt_o), 32'd0);
        model_reset();
        @(negedge clk);
        req_valid_i = '0;
        rst_n       = 1'b1;
    endtask

    logic [15:0] s_prev;

    initial begin
        rst_n       = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        flush_i     = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_rm_i    = '0;
        do_reset();

        // Single op: fixed latency of L cycles.
        step(2'b01, 2'b11, 1'b0);
        check("single_ready", 32'(obs_ready), 32'h1);
        step(2'b00, 2'b11, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        check("single_rsp", 32'(obs_rsp), 32'h1);
        check("single_data", 32'(obs_data), 32'(obs_res));

        // Fairness under continuous contention.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(2'b11, 2'b11, 1'b0);
            check("fair_grant", 32'(obs_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            check("fair_issue", 32'(obs_mv), 32'd1);
        end
        check("fair_stall", 32'(obs_stall), 32'd0);

        // Backpressure with a bubble between the head and stage 0.
        do_reset();
        step(2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        check("bp_en_bubble", 32'(obs_en), 32'h3);
        s_prev = obs_stall;
        step(2'b11, 2'b00, 1'b0);
        check("bp_stall_inc", 32'(obs_stall - s_prev), 32'd1);
        s_prev = obs_stall;
        step(2'b11, 2'b00, 1'b0);
        check("bp_stall_inc2", 32'(obs_stall - s_prev), 32'd1);
        check("bp_en_full", 32'(obs_en), 32'h0);
        check("bp_ready_full", 32'(obs_ready), 32'h0);

        // Flush with a full pipeline and a competing request.
        do_reset();
        repeat (3) step(2'b01, 2'b11, 1'b0);
        step(2'b10, 2'b11, 1'b1);
        check("flush_no_issue", 32'(obs_mv), 32'd0);
        check("flush_ready", 32'(obs_ready), 32'd0);
        step(2'b00, 2'b11, 1'b0);
        check("flush_busy", 32'(obs_busy), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("flush_no_rsp", 32'(obs_rsp), 32'd0);
            step(2'b00, 2'b11, 1'b0);
        end

        // Reset while ops are in flight.
        step(2'b11, 2'b11, 1'b0);
        step(2'b11, 2'b11, 1'b0);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(2'b00, 2'b11, 1'b0);
            check("rstmid_no_rsp", 32'(obs_rsp), 32'd0);
        end
        step(2'b11, 2'b11, 1'b0);
        check("rstmid_grant0", 32'(obs_ready), 32'h1);

        // Random traffic with occasional flushes and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(N'($urandom),
                     N'($urandom) | N'($urandom),
                     ($urandom_range(0, 29) == 0));
            end
        end

        // Saturation of the stall counter.
        do_reset();
        step(2'b01, 2'b00, 1'b0);
        for (int c = 0; c < 70000; c++) begin
            step(N'($urandom), 2'b00, 1'b0);
        end
        check("sat_value", 32'(obs_stall), 32'hFFFF);
        step(2'b00, 2'b00, 1'b0);
        check("sat_hold", 32'(obs_stall), 32'hFFFF);
        step(2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b00, 1'b0);
        check("sat_after_flush", 32'(obs_stall), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmul_share_ctrl.md
FMUL_SHARE_CTRL -- requirements
Module: fmul_share_ctrl

Interface
REQ-001 Parameters SHALL be: EXPWIDTH, default 5, exponent width; PRECISION, default 11, significand width incl. hidden bit; LAT, default 3, fmul pipeline register stages (>=2); NREQ, default 2, requesters (>=2). W = EXPWIDTH+PRECISION.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NREQ  per-requester operand valid.
- req_ready_o  out  NREQ  per-requester accept.
- req_a_i, req_b_i  in  NREQ*W each  operands; requester i at bits [i*W +: W].
- req_rm_i  in  NREQ*3  rounding modes.
- flush_i  in  1  synchronous kill of all in-flight ops.
- mul_valid_o  out  1  issue strobe into fmul stage 1.
- mul_a_o, mul_b_o  out  W each  issued operands.
- mul_rm_o  out  3  issued rounding mode.
- stage_en_o  out  LAT  load enable of fmul pipeline register k.
- mul_result_i  in  W  result from the last fmul stage.
- mul_fflags_i  in  5  exception flags from the last fmul stage.
- rsp_valid_o  out  NREQ  result valid, one-hot or zero.
- rsp_ready_i  in  NREQ  per-requester result accept.
- rsp_data_o  out  W  shared result bus.
- rsp_fflags_o  out  5  shared flags bus.
- busy_o  out  1  any stage valid.
- stall_cnt_o  out  16  saturating count of output-stall cycles.

Function
REQ-004 State SHALL be: vld[0..LAT-1], id[0..LAT-1] (clog2(NREQ) bits), round-robin pointer rr, stall_cnt.
REQ-005 Advance SHALL be combinational: adv[LAT-1] = !vld[LAT-1] | rsp_ready_i[id[LAT-1]]; adv[k] = !vld[k] | adv[k+1] for k < LAT-1. Bubbles collapse.
REQ-006 stage_en_o[k] SHALL equal adv[k] & !flush_i.
REQ-007 Grant SHALL be the first i with req_valid_i[i] set, searching rr, rr+1, ... modulo NREQ. Grant is combinational.
REQ-008 req_ready_o[i] SHALL equal (i == grant) & adv[0] & !flush_i. Issue occurs when a valid/ready pair is high.
REQ-009 On issue, mul_valid_o SHALL be 1 and mul_a_o/mul_b_o/mul_rm_o SHALL carry the granted requester's fields. When not issuing, mul_valid_o SHALL be 0 and the data outputs SHALL be 0.
REQ-010 On each edge with adv[k] and no flush, the pipeline SHALL update as follows. vld[0] <= issue and id[0] <= grant. vld[k] <= vld[k-1] and id[k] <= id[k-1] for k >= 1. Otherwise the stage holds.
REQ-011 rsp_valid_o[i] SHALL equal vld[LAT-1] & (id[LAT-1] == i). rsp_data_o and rsp_fflags_o SHALL pass mul_result_i and mul_fflags_i through when vld[LAT-1], else 0.
REQ-012 Latency SHALL be exactly LAT cycles when unstalled: accept in cycle c gives rsp_valid in cycle c+LAT.
REQ-013 After an issue, rr SHALL become (grant+1) mod NREQ. rr SHALL be unchanged otherwise.
REQ-014 flush_i SHALL clear all vld on the next edge. It SHALL suppress issue and all stage enables in that cycle and leave rr unchanged. Flush wins over simultaneous issue or response.
REQ-015 stall_cnt SHALL increment when vld[LAT-1] & !adv[LAT-1], and SHALL saturate at 0xFFFF. Flush SHALL not clear it.
REQ-016 busy_o SHALL equal the OR of vld.
REQ-017 A requester SHALL receive responses in its issue order, since the pipeline is in-order.

Reset
REQ-018 While rst_n is low, vld, id, rr and stall_cnt SHALL be 0, independent of clk. All outputs are then 0 except stage_en_o, which is all-ones.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight ops with no response emitted. The first grant after reset SHALL go to requester 0.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (LAT=3, NREQ=2):
- Single op: req 0 valid in cycle 0, rsp_ready all 1 -> req_ready_o[0]=1 in cycle 0, rsp_valid_o=01 in cycle 3, rsp_data_o = mul_result_i.
- Fairness: both requesters valid continuously, rsp_ready=11 -> grants 0,1,0,1; issue every cycle; stall_cnt stays 0.
- Backpressure and bubble collapse: vld=101 (stage 2 holds id 0), rsp_ready_i[0]=0 -> stage_en_o=011, stall_cnt increments by 1 per cycle. With the pipeline full -> stage_en_o=000 and req_ready_o=00.
- Flush: 3 ops in flight plus flush_i=1 with req 1 valid -> no issue that cycle, busy_o=0 next cycle, no rsp_valid ever for the killed ops.
- Reset mid-operation: rst_n low for 1 cycle with 2 ops in flight -> all outputs per REQ-018 immediately, no responses after release, next grant to req 0.
- Saturation: hold output stall for 70000 cycles -> stall_cnt_o=0xFFFF and stays there.
